// File: rtl/famicom_pad_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : famicom_pkg
// Purpose  : Shared types and helpers for the Famicom/SNES pad scanner.
//            - state_t   : scanner FSM states
//            - NES_BITS  : bits per frame for an NES/Famicom pad
//            - SNES_BITS : bits per frame for an SNES pad
//            - frame_len : cycles from first LATCH cycle to last LOW cycle
//            - sel_width : width of a pad-select field (never below 1)
// Revision : 1.0 - initial release
// ============================================================================
package famicom_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;

  // Latch lasts 2H, bit 0 needs one LOW phase (H), every further bit a
  // HIGH+LOW pair (2H).
  function automatic int frame_len(input int half_per, input int bits);
    return 3 * half_per + 2 * half_per * (bits - 1);
  endfunction

  function automatic int sel_width(input int num_pads);
    return (num_pads > 1) ? $clog2(num_pads) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/famicom_pad_scanner_sync.sv
`default_nettype none
// ============================================================================
// Module   : famicom_sync
// Purpose  : Parametrised-width two-flop synchroniser for asynchronous pad
//            lines. Resets to all-ones, i.e. every line idle high.
// Ports    : clk     - system clock
//            reset_n - synchronous active-low reset
//            d       - asynchronous input lines
//            q       - synchronised lines (two-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module famicom_sync
  import famicom_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/famicom_pad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : famicom_pad_scanner
// Purpose  : Autonomous poller for 1-4 NES/Famicom (8-bit) or SNES (16-bit)
//            serial pads sharing one latch/pulse pair, with a passthrough
//            mode that lets a core bit-bang one selected pad directly.
// Ports    : clk, reset_n        - clock, synchronous active-low reset
//            poll_en             - enable periodic auto-poll
//            poll_req            - single-cycle manual poll request
//            passthrough         - 1 = core drives the pad lines
//            pass_sel            - pad routed to core_data in passthrough
//            core_latch/pulse    - core-driven pad lines (passthrough)
//            core_data           - selected raw pad data (1 in scanner mode)
//            pad_latch/pulse     - to pads
//            pad_data            - from pads, async, active-low
//            buttons             - pad p at [p*BITS_PER_PAD +: BITS_PER_PAD],
//                                  bit k = k-th shifted bit, 1 = pressed
//            buttons_valid       - one-cycle strobe on buttons update
//            busy                - scan in progress
// Revision : 1.0 - initial release
// ============================================================================
module famicom_pad_scanner
  import famicom_pkg::*;
#(
  parameter int          NUM_PADS     = 2,
  parameter int          BITS_PER_PAD = 8,
  parameter int          HALF_PER     = 4,
  parameter logic [15:0] POLL_PERIOD  = 16'd833
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               poll_en,
  input  logic                               poll_req,
  input  logic                               passthrough,
  input  logic [sel_width(NUM_PADS)-1:0]     pass_sel,
  input  logic                               core_latch,
  input  logic                               core_pulse,
  output logic                               core_data,
  output logic                               pad_latch,
  output logic                               pad_pulse,
  input  logic [NUM_PADS-1:0]                pad_data,
  output logic [NUM_PADS*BITS_PER_PAD-1:0]   buttons,
  output logic                               buttons_valid,
  output logic                               busy
);

  localparam int c_sel_w = sel_width(NUM_PADS);
  localparam int c_cnt_w = $clog2(2 * HALF_PER);
  localparam int c_bit_w = $clog2(BITS_PER_PAD);

  localparam logic [c_cnt_w-1:0] c_latch_last = c_cnt_w'(2 * HALF_PER - 1);
  localparam logic [c_cnt_w-1:0] c_half_last  = c_cnt_w'(HALF_PER - 1);
  localparam logic [c_bit_w-1:0] c_bit_last   = c_bit_w'(BITS_PER_PAD - 1);
  localparam logic [15:0]        c_poll_last  = POLL_PERIOD - 16'd1;

  state_t                            r_state;
  logic [c_cnt_w-1:0]                r_half;
  logic [c_bit_w-1:0]                r_bit;
  logic                              r_pending;
  logic [NUM_PADS*BITS_PER_PAD-1:0]  r_shift;
  logic [NUM_PADS*BITS_PER_PAD-1:0]  r_buttons;
  logic                              r_valid;
  logic                              r_busy;
  logic                              r_latch;
  logic                              r_pulse;
  logic [15:0]                       r_poll_cnt;

  logic [NUM_PADS-1:0]               w_pad_sync;
  logic [NUM_PADS*BITS_PER_PAD-1:0]  w_shift_next;
  logic                              w_poll_fire;
  logic                              w_start;
  logic                              w_sel_data;

  famicom_sync #(
    .WIDTH (NUM_PADS)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pad_data),
    .q       (w_pad_sync)
  );

  // Each pad shifts right, new (inverted) sample entering at the MSB, so the
  // first bit of the frame ends up at bit 0 after BITS_PER_PAD samples.
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    assign w_shift_next[p*BITS_PER_PAD +: BITS_PER_PAD] =
      {~w_pad_sync[p], r_shift[p*BITS_PER_PAD+1 +: BITS_PER_PAD-1]};
  end

  // Auto-poll timer: free-runs while enabled, independent of the scanner,
  // so the poll rate is not stretched by frame length.
  assign w_poll_fire = poll_en && !passthrough && (r_poll_cnt == c_poll_last);
  assign w_start     = (w_poll_fire || poll_req) && !passthrough;

  always_ff @(posedge clk) begin
    if (!reset_n || !poll_en || passthrough) begin
      r_poll_cnt <= '0;
    end else if (r_poll_cnt == c_poll_last) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_half    <= '0;
      r_bit     <= '0;
      r_pending <= 1'b0;
      r_shift   <= '0;
      r_buttons <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_latch   <= 1'b0;
      r_pulse   <= 1'b0;
    end else if (passthrough) begin
      // Abort: buttons and shift registers are left untouched.
      r_state   <= IDLE;
      r_half    <= '0;
      r_bit     <= '0;
      r_pending <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_latch   <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // One pending slot; repeated requests while busy collapse into it.
      if (w_start && (r_state != IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= LATCH;
            r_latch <= 1'b1;
            r_busy  <= 1'b1;
            r_half  <= '0;
            r_bit   <= '0;
          end
        end
        LATCH: begin
          if (r_half == c_latch_last) begin
            r_state <= LOW;
            r_latch <= 1'b0;
            r_half  <= '0;
          end else begin
            r_half <= r_half + c_cnt_w'(1);
          end
        end
        LOW: begin
          if (r_half == c_half_last) begin
            r_half  <= '0;
            r_shift <= w_shift_next;
            if (r_bit == c_bit_last) begin
              // Load buttons on the edge into DONE so the new word and the
              // strobe are both visible during the DONE cycle.
              r_state   <= DONE;
              r_buttons <= w_shift_next;
              r_valid   <= 1'b1;
            end else begin
              r_state <= HIGH;
              r_pulse <= 1'b1;
            end
          end else begin
            r_half <= r_half + c_cnt_w'(1);
          end
        end
        HIGH: begin
          if (r_half == c_half_last) begin
            r_state <= LOW;
            r_pulse <= 1'b0;
            r_half  <= '0;
            r_bit   <= r_bit + c_bit_w'(1);
          end else begin
            r_half <= r_half + c_cnt_w'(1);
          end
        end
        DONE: begin
          r_half <= '0;
          r_bit  <= '0;
          // A start landing in DONE itself is taken directly, like pending.
          if (r_pending || w_start) begin
            r_state   <= LATCH;
            r_latch   <= 1'b1;
            r_pending <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_latch <= 1'b0;
          r_pulse <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range selects fall back to pad 0 (the default assignment).
  always_comb begin
    w_sel_data = pad_data[0];
    for (int p = 0; p < NUM_PADS; p++) begin
      if (pass_sel == c_sel_w'(p)) begin
        w_sel_data = pad_data[p];
      end
    end
  end

  assign pad_latch     = passthrough ? core_latch : r_latch;
  assign pad_pulse     = passthrough ? core_pulse : r_pulse;
  assign core_data     = passthrough ? w_sel_data : 1'b1;
  assign buttons       = r_buttons;
  assign buttons_valid = r_valid;
  assign busy          = r_busy;

endmodule
`default_nettype wire
